// File: rtl/pcs_pkg.sv
// Shared types and helpers for the PCS receive link controller.
package pcs_pkg;

  typedef enum logic [2:0] {
    LS_RESET       = 3'd0,
    LS_WAIT_BLOCK  = 3'd1,
    LS_WAIT_AM     = 3'd2,
    LS_WAIT_DESKEW = 3'd3,
    LS_UP          = 3'd4
  } link_state_e;

  // Sync headers 00 and 11 never appear on a healthy 64b/66b lane.
  function automatic logic hdr_invalid(input logic [1:0] head);
    return (head == 2'b00) || (head == 2'b11);
  endfunction

endpackage

// File: rtl/pcs_rx_link_ctrl_if.sv
// Status/control bundle between the PCS RX lanes and the link controller.
interface pcs_rx_link_ctrl_if #(
  parameter int LANE_N    = 4,
  parameter int HEAD_W    = 2,
  parameter int BER_CNT_W = 7
);
  logic [LANE_N-1:0]        valid_i;
  logic [LANE_N*HEAD_W-1:0] head_i;
  logic [LANE_N-1:0]        bs_lock_v_i;
  logic [LANE_N-1:0]        am_lock_v_i;
  logic                     deskew_done_i;
  logic                     relock_o;
  logic                     align_status_o;
  logic                     hi_ber_o;
  logic                     link_up_o;
  logic [BER_CNT_W-1:0]     ber_cnt_o;
  logic [2:0]               state_o;

  modport master (
    output valid_i, head_i, bs_lock_v_i, am_lock_v_i, deskew_done_i,
    input  relock_o, align_status_o, hi_ber_o, link_up_o, ber_cnt_o, state_o
  );

  modport slave (
    input  valid_i, head_i, bs_lock_v_i, am_lock_v_i, deskew_done_i,
    output relock_o, align_status_o, hi_ber_o, link_up_o, ber_cnt_o, state_o
  );
endinterface

// File: rtl/ber_mon_rx.sv
// High-BER monitor: counts invalid sync headers per window, flags hi_ber.
module ber_mon_rx
  import pcs_pkg::*;
#(
  parameter int LANE_N      = 4,
  parameter int HEAD_W      = 2,
  parameter int BER_WIN_CYC = 19531,
  parameter int BER_THRESH  = 97,
  parameter int BER_CNT_W   = 7
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           run,
  input  logic [LANE_N-1:0]              valid,
  input  logic [LANE_N-1:0][HEAD_W-1:0]  head,
  output logic                           hi_ber,
  output logic [BER_CNT_W-1:0]           ber_cnt
);
  localparam int WIN_W = (BER_WIN_CYC > 1) ? $clog2(BER_WIN_CYC) : 1;
  localparam int SUM_W = BER_CNT_W + 2;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WIN_CYC - 1);
  localparam logic [SUM_W-1:0] THRESH   = SUM_W'(BER_THRESH);

  logic [LANE_N-1:0] bad;
  logic [WIN_W-1:0]  win;
  logic [SUM_W-1:0]  sum, sat;

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    assign bad[l] = valid[l] & hdr_invalid(head[l][1:0]);
  end

  // Wide adder so count + LANE_N cannot wrap before saturation.
  assign sum = SUM_W'(ber_cnt) + SUM_W'($countones(bad));
  assign sat = (sum >= THRESH) ? THRESH : sum;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      win     <= '0;
      ber_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (!run) begin
      win     <= '0;
      ber_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (win == WIN_LAST) begin
      // A window that itself hit the threshold keeps hi_ber asserted.
      win     <= '0;
      ber_cnt <= '0;
      hi_ber  <= (sat == THRESH);
    end else begin
      win     <= win + WIN_W'(1);
      ber_cnt <= BER_CNT_W'(sat);
      hi_ber  <= hi_ber | (sat == THRESH);
    end
  end

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// Link bring-up FSM for the multi-lane PCS RX path, plus BER health monitor.
module pcs_rx_link_ctrl
  import pcs_pkg::*;
#(
  parameter int LANE_N        = 4,
  parameter int HEAD_W        = 2,
  parameter int BER_WIN_CYC   = 19531,
  parameter int BER_THRESH    = 97,
  parameter int BER_CNT_W     = 7,
  parameter int DESKEW_TO_CYC = 65536
) (
  input  logic             clk,
  input  logic             nreset,
  pcs_rx_link_ctrl_if.slave lk
);
  localparam logic [2:0] S_RESET       = LS_RESET;
  localparam logic [2:0] S_WAIT_BLOCK  = LS_WAIT_BLOCK;
  localparam logic [2:0] S_WAIT_AM     = LS_WAIT_AM;
  localparam logic [2:0] S_WAIT_DESKEW = LS_WAIT_DESKEW;
  localparam logic [2:0] S_UP          = LS_UP;

  localparam int TO_W = (DESKEW_TO_CYC > 1) ? $clog2(DESKEW_TO_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DESKEW_TO_CYC - 1);

  logic [2:0]      state, nxt;
  logic            relock_nxt, relock_q;
  logic [TO_W-1:0] to_cnt;
  logic            all_bs, all_am;
  logic            hi_ber;
  logic [BER_CNT_W-1:0] ber_cnt;

  assign all_bs = &lk.bs_lock_v_i;
  assign all_am = &lk.am_lock_v_i;

  always_comb begin
    nxt        = state;
    relock_nxt = 1'b0;
    case (state)
      S_RESET:       nxt = S_WAIT_BLOCK;
      S_WAIT_BLOCK:  if (all_bs) nxt = S_WAIT_AM;
      S_WAIT_AM:     if (all_am) nxt = S_WAIT_DESKEW;
      S_WAIT_DESKEW: begin
        if (lk.deskew_done_i) nxt = S_UP;
        else if (to_cnt == TO_LAST) begin
          nxt        = S_WAIT_AM;
          relock_nxt = 1'b1;
        end
      end
      S_UP:          nxt = S_UP;
      default:       nxt = S_RESET;
    endcase
    // Lock loss overrides any forward progress.
    if (state != S_RESET) begin
      if (!all_bs) begin
        nxt        = S_WAIT_BLOCK;
        relock_nxt = 1'b0;
      end else if (!all_am && (state == S_WAIT_DESKEW || state == S_UP)) begin
        nxt        = S_WAIT_AM;
        relock_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= S_RESET;
      relock_q <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state    <= nxt;
      relock_q <= relock_nxt;
      to_cnt   <= (state == S_WAIT_DESKEW) ? to_cnt + TO_W'(1) : '0;
    end
  end

  ber_mon_rx #(
    .LANE_N      (LANE_N),
    .HEAD_W      (HEAD_W),
    .BER_WIN_CYC (BER_WIN_CYC),
    .BER_THRESH  (BER_THRESH),
    .BER_CNT_W   (BER_CNT_W)
  ) u_ber (
    .clk     (clk),
    .nreset  (nreset),
    .run     (all_bs),
    .valid   (lk.valid_i),
    .head    (lk.head_i),
    .hi_ber  (hi_ber),
    .ber_cnt (ber_cnt)
  );

  assign lk.relock_o       = relock_q;
  assign lk.align_status_o = (state == S_UP);
  assign lk.hi_ber_o       = hi_ber;
  assign lk.link_up_o      = (state == S_UP) & ~hi_ber;
  assign lk.ber_cnt_o      = ber_cnt;
  assign lk.state_o        = state;

endmodule
